// File: rtl/mmul_feeder.sv
// Operand sequencer for the 4x4 matrix-vector multiplier: loads A0..A3 and P from a word stream,
// waits SETTLE cycles, captures the result and streams it out. Optional macro: MMUL_FEEDER_MATRIX_HOLD_EN.
module mmul_feeder #(
    parameter int W      = 10,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
`ifdef MMUL_FEEDER_MATRIX_HOLD_EN
    input  logic           hold_matrix,
`endif
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic [4*W-1:0] mm_a0,
    output logic [4*W-1:0] mm_a1,
    output logic [4*W-1:0] mm_a2,
    output logic [4*W-1:0] mm_a3,
    output logic [4*W-1:0] mm_p,
    input  logic [4*W-1:0] mm_c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           busy
);

    typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_OUT} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t                   state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [7:0]               settle_q, settle_d;
    logic [1:0]               lane_q, lane_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [W-1:0]             out_data_q, out_data_d;
    logic                     busy_q, busy_d;
    logic [3:0][3:0][W-1:0]   a_q, a_d;
    logic [3:0][W-1:0]        p_q, p_d;
    logic [3:0][W-1:0]        res_q, res_d;

    logic                     in_xfer;
    logic                     job_done;
    logic                     skip_matrix;
    logic [4:0]               eff_idx;
    logic [1:0]               next_lane;

    assign in_xfer   = (state_q == S_LOAD) && in_valid && in_ready_q;
    assign job_done  = (state_q == S_OUT) && out_ready && (lane_q == 2'd3);
    // Word slot 0..19 in load order; a vector-only job starts at slot 16.
    assign eff_idx   = skip_matrix ? (cnt_q + 5'd16) : cnt_q;
    assign next_lane = lane_q + 2'd1;

`ifdef MMUL_FEEDER_MATRIX_HOLD_EN
    logic loaded_q, loaded_d;
    logic p_only_q, p_only_d;

    assign skip_matrix = (cnt_q == 5'd0) ? (hold_matrix && loaded_q) : p_only_q;

    always_comb begin
        loaded_d = loaded_q;
        p_only_d = p_only_q;
        if (in_xfer && cnt_q == 5'd0)
            p_only_d = skip_matrix;
        if (in_xfer && eff_idx == 5'd15)
            loaded_d = 1'b1;
        if (job_done)
            p_only_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loaded_q <= 1'b0;
            p_only_q <= 1'b0;
        end else begin
            loaded_q <= loaded_d;
            p_only_q <= p_only_d;
        end
    end
`else
    assign skip_matrix = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        lane_d      = lane_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        a_d         = a_q;
        p_d         = p_q;
        res_d       = res_q;
        case (state_q)
            S_LOAD: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (in_xfer) begin
                    // First word of each group lands in the most significant lane.
                    if (eff_idx[4])
                        p_d[~eff_idx[1:0]] = in_data;
                    else
                        a_d[eff_idx[3:2]][~eff_idx[1:0]] = in_data;
                    cnt_d = cnt_q + 5'd1;
                    if (eff_idx == 5'd19) begin
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                        settle_d   = 8'd0;
                        state_d    = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    res_d       = mm_c;
                    out_valid_d = 1'b1;
                    out_data_d  = mm_c[4*W-1:3*W];
                    lane_d      = 2'd0;
                    state_d     = S_OUT;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (lane_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        cnt_d       = 5'd0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_LOAD;
                    end else begin
                        lane_d     = next_lane;
                        out_data_d = res_q[~next_lane];
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= 5'd0;
            settle_q    <= 8'd0;
            lane_q      <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            p_q         <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            lane_q      <= lane_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            a_q         <= a_d;
            p_q         <= p_d;
            res_q       <= res_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign mm_a0     = a_q[0];
    assign mm_a1     = a_q[1];
    assign mm_a2     = a_q[2];
    assign mm_a3     = a_q[3];
    assign mm_p      = p_q;

endmodule

// File: tb/tb_mmul_feeder.sv
// Directed, table-driven bench for mmul_feeder with a behavioural 4x4 multiplier on mm_c.
module tb_mmul_feeder;

    localparam int W      = 10;
    localparam int SETTLE = 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [4*W-1:0] mm_a0, mm_a1, mm_a2, mm_a3, mm_p, mm_c;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           busy;
`ifdef MMUL_FEEDER_MATRIX_HOLD_EN
    logic           hold_matrix;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [0:19][W-1:0] words;
        int                 n_words;
        bit                 gaps;
        int                 ready_mode;
        bit                 hold;
        logic [0:3][W-1:0]  exp_out;
        logic [4*W-1:0]     exp_a0;
        logic [4*W-1:0]     exp_p;
    } vec_t;

    vec_t vecs[$];

    mmul_feeder #(.W(W), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MMUL_FEEDER_MATRIX_HOLD_EN
        .hold_matrix(hold_matrix),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mm_a0      (mm_a0),
        .mm_a1      (mm_a1),
        .mm_a2      (mm_a2),
        .mm_a3      (mm_a3),
        .mm_p       (mm_p),
        .mm_c       (mm_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: each result lane is a row dot P, wrapped mod 2^W.
    function automatic logic [W-1:0] dot(input logic [3:0][W-1:0] r, input logic [3:0][W-1:0] p);
        logic [W-1:0]   s;
        logic [2*W-1:0] prod;
        s = '0;
        for (int j = 0; j < 4; j++) begin
            prod = r[j] * p[j];
            s    = s + prod[W-1:0];
        end
        return s;
    endfunction

    assign mm_c = {dot(mm_a0, mm_p), dot(mm_a1, mm_p), dot(mm_a2, mm_p), dot(mm_a3, mm_p)};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendWords(input logic [0:19][W-1:0] w, input int n, input bit gaps);
        int cyc;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = w[k];
            cyc = 0;
            while (!in_ready && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (!in_ready) begin
                checkOutput("in_ready timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [0:3][W-1:0] got;
        int  nout, low, busy_bad, stall;
        bit  seen_valid, done;
`ifdef MMUL_FEEDER_MATRIX_HOLD_EN
        hold_matrix = v.hold;
`endif
        sendWords(v.words, v.n_words, v.gaps);
`ifdef MMUL_FEEDER_MATRIX_HOLD_EN
        hold_matrix = 1'b0;
`endif
        // Junk on the input while the feeder is busy must be ignored.
        in_valid = 1'b1;
        in_data  = 10'd777;
        got = '0;
        nout = 0; low = 0; busy_bad = 0; stall = 0;
        seen_valid = 1'b0; done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (in_ready) begin
                in_valid = 1'b0;
                done = 1'b1;
                break;
            end
            low++;
            if (!busy) busy_bad++;
            if (out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                checkOutput($sformatf("job%0d mm_a0", idx), 64'(mm_a0), 64'(v.exp_a0));
                checkOutput($sformatf("job%0d mm_p", idx), 64'(mm_p), 64'(v.exp_p));
            end
            if (v.ready_mode == 1 && seen_valid && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                checkOutput($sformatf("job%0d stall hold", idx), 64'(out_data), 64'(v.exp_out[0]));
            end else if (v.ready_mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (nout < 4) got[nout] = out_data;
                nout++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput($sformatf("job%0d completed", idx), 64'(done), 64'd1);
        checkOutput($sformatf("job%0d out count", idx), 64'(nout), 64'd4);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("job%0d out word %0d", idx, k), 64'(got[k]), 64'(v.exp_out[k]));
        checkOutput($sformatf("job%0d busy while not ready", idx), 64'(busy_bad), 64'd0);
        if (v.ready_mode == 0)
            checkOutput($sformatf("job%0d in_ready low cycles", idx), 64'(low), 64'(SETTLE + 4));
    endtask

    initial begin
        vec_t v;
        logic [0:19][W-1:0] basic_words;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef MMUL_FEEDER_MATRIX_HOLD_EN
        hold_matrix = 1'b0;
`endif
        basic_words = {10'd5, 10'd6, 10'd5, 10'd3, 10'd18, 10'd4, 10'd10, 10'd0,
                       10'd6, 10'd18, 10'd7, 10'd12, 10'd1, 10'd14, 10'd4, 10'd2,
                       10'd1, 10'd1, 10'd1, 10'd1};

        v.words = basic_words; v.n_words = 20; v.gaps = 1'b0; v.ready_mode = 0; v.hold = 1'b0;
        v.exp_out = {10'd19, 10'd32, 10'd43, 10'd21};
        v.exp_a0  = {10'd5, 10'd6, 10'd5, 10'd3};
        v.exp_p   = {10'd1, 10'd1, 10'd1, 10'd1};
        vecs.push_back(v);
`ifdef MMUL_FEEDER_MATRIX_HOLD_EN
        v.words = '0;
        v.words[0] = 10'd2;
        v.n_words = 4; v.hold = 1'b1;
        v.exp_out = {10'd10, 10'd36, 10'd12, 10'd2};
        v.exp_p   = {10'd2, 10'd0, 10'd0, 10'd0};
        vecs.push_back(v);
        v.words = basic_words; v.n_words = 20; v.hold = 1'b0;
        v.exp_out = {10'd19, 10'd32, 10'd43, 10'd21};
        v.exp_p   = {10'd1, 10'd1, 10'd1, 10'd1};
`endif
        v.gaps = 1'b1;
        vecs.push_back(v);
        v.gaps = 1'b0; v.ready_mode = 1;
        vecs.push_back(v);
        v.ready_mode = 0;
        v.words[0] = 10'd1023; v.words[1] = 10'd1023; v.words[2] = 10'd0; v.words[3] = 10'd0;
        v.exp_out = {10'd1022, 10'd32, 10'd43, 10'd21};
        v.exp_a0  = {10'd1023, 10'd1023, 10'd0, 10'd0};
        vecs.push_back(v);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset mm_a0", 64'(mm_a0), 64'd0);
        checkOutput("reset mm_p", 64'(mm_p), 64'd0);
        checkOutput("reset out_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        checkOutput("in_ready after reset", 64'(in_ready), 64'd1);

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        $display("[TB] reset in the middle of a load");
        sendWords(basic_words, 7, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midload mm_a0", 64'(mm_a0), 64'd0);
        checkOutput("midload mm_a1", 64'(mm_a1), 64'd0);
        checkOutput("midload mm_p", 64'(mm_p), 64'd0);
        checkOutput("midload in_ready", 64'(in_ready), 64'd0);
        checkOutput("midload busy", 64'(busy), 64'd0);
        applyStimulus(vecs[0], 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
